// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    // funct3 size codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_WR,
        ST_RESP,
        ST_ERR
    } state_t;

    // Legal when the size code exists for the direction and the address is naturally aligned
    function automatic logic lsu_is_legal(input logic we, input logic [2:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        if (we && size[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extraction with sign/zero extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] load_c,
    output logic [DATA_W-1:0] merge_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;

    // Extract the addressed lane and extend it; splice new data into the old word
    always_comb begin
        byte_v  = old_word[{addr_lo, 3'b000} +: 8];
        half_v  = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        sx      = ~size[2];
        load_c  = old_word;
        merge_c = old_word;
        case (size[1:0])
            2'b00: begin
                load_c = {{24{byte_v[7] & sx}}, byte_v};
                merge_c[{addr_lo, 3'b000} +: 8] = wd[7:0];
            end
            2'b01: begin
                load_c = {{16{half_v[15] & sx}}, half_v};
                if (addr_lo[1]) begin
                    merge_c[31:16] = wd[15:0];
                end else begin
                    merge_c[15:0] = wd[15:0];
                end
            end
            default: begin
                load_c  = old_word;
                merge_c = wd;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-aligned memory accesses, RMW for SB/SH.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wd_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rd_i
);

    state_t state, state_next;

    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wd_q;

    logic              accept;
    logic              ready_n, done_n, err_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wd_n, rd_n;
    logic [31:0]       load_c, merge_c;

    lsu_align u_align (
        .size    (size_q),
        .addr_lo (addr_lo_q),
        .old_word(mem_rd_i),
        .wd      (wd_q),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

    assign accept = (state == ST_IDLE) && req_i;

    // Next state plus next values of the registered outputs
    always_comb begin
        state_next = state;
        mem_we_n   = 1'b0;
        mem_addr_n = '0;
        mem_wd_n   = '0;
        rd_n       = rd_o;
        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    if (lsu_is_legal(we_i, size_i, addr_i[1:0])) begin
                        state_next = ST_ACCESS;
                        mem_addr_n = {addr_i[ADDR_W-1:2], 2'b00};
                        if (we_i && (size_i == F3_W)) begin
                            mem_we_n = 1'b1;
                            mem_wd_n = wd_i;
                        end
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rd_n       = load_c;
                    state_next = ST_RESP;
                end else if (size_q != F3_W) begin
                    state_next = ST_RMW_WR;
                    mem_addr_n = mem_addr_o;
                    mem_we_n   = 1'b1;
                    mem_wd_n   = merge_c;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_RMW_WR: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            ST_ERR:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        ready_n = (state_next == ST_IDLE);
        done_n  = (state_next == ST_RESP) || (state_next == ST_ERR);
        err_n   = (state_next == ST_ERR);
    end

    // State, request and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_lo_q  <= '0;
            wd_q       <= '0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_o       <= '0;
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
            mem_we_o   <= 1'b0;
        end else begin
            state      <= state_next;
            ready_o    <= ready_n;
            done_o     <= done_n;
            err_o      <= err_n;
            rd_o       <= rd_n;
            mem_addr_o <= mem_addr_n;
            mem_wd_o   <= mem_wd_n;
            mem_we_o   <= mem_we_n;
            if (accept) begin
                we_q      <= we_i;
                size_q    <= size_i;
                addr_lo_q <= addr_i[1:0];
                wd_q      <= wd_i;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu against a word-array memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic        ready, done, err, mem_we;
    logic [31:0] rd, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] model_rd;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          issue;
        logic [7:0]  widx;
        logic [31:0] word;
        int          wes;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   we_total = 0;
    int   we_base = 0;

    lsu #(.ADDR_W(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .we_i      (we),
        .size_i    (size),
        .addr_i    (addr),
        .wd_i      (wd),
        .ready_o   (ready),
        .done_o    (done),
        .err_o     (err),
        .rd_o      (rd),
        .mem_addr_o(mem_addr),
        .mem_wd_o  (mem_wd),
        .mem_we_o  (mem_we),
        .mem_rd_i  (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Data memory: combinational read, write on the posedge with mem_we
    assign mem_rd = mem[mem_addr[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_legal(input logic w, input logic [2:0] s, input logic [1:0] lo);
        logic ok;
        if (s == 3'd0 || s == 3'd4)      ok = 1'b1;
        else if (s == 3'd1 || s == 3'd5) ok = (lo % 2 == 0);
        else if (s == 3'd2)              ok = (lo == 0);
        else                             ok = 1'b0;
        if (w && s >= 3'd4) ok = 1'b0;
        return ok;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected response
    always @(negedge clk) begin
        if (mem_we) we_total = we_total + 1;
        if (mem_we) chk("mem_addr_aligned", {30'b0, mem_addr[1:0]}, 32'h0);
        if (done) begin
            if (q.size() == 0) begin
                chk("done_without_request", {31'b0, done}, 32'h0);
            end else begin
                me = q.pop_front();
                chk("err", {31'b0, err}, {31'b0, me.err});
                chk("rd", rd, me.rd);
                chk("latency", cyc - me.issue, me.lat);
                chk("mem_word", mem[me.widx], me.word);
                chk("write_count", we_total - we_base, me.wes);
                we_base = we_total;
            end
        end
    end

    // Drive one request, predict its outcome, and check the busy window
    task automatic issue(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int n;
        int sh;
        logic [31:0] v, m;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_wait", {31'b0, ready}, 32'h1);
            return;
        end
        e.widx = a[9:2];
        e.err  = !model_legal(w, s, a[1:0]);
        v      = ref_mem[e.widx];
        e.wes  = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (!w) begin
            e.lat = 2;
            if (s == 3'd2) begin
                model_rd = v;
            end else if (s[1:0] == 2'b00) begin
                sh = 8 * int'(a[1:0]);
                model_rd = (v >> sh) & 32'hFF;
                if (s == 3'd0 && model_rd >= 32'd128) model_rd = model_rd | 32'hFFFFFF00;
            end else begin
                sh = 16 * int'(a[1]);
                model_rd = (v >> sh) & 32'hFFFF;
                if (s == 3'd1 && model_rd >= 32'h8000) model_rd = model_rd | 32'hFFFF0000;
            end
        end else begin
            e.wes = 1;
            if (s == 3'd2) begin
                e.lat = 2;
                ref_mem[e.widx] = d;
            end else begin
                e.lat = 3;
                if (s == 3'd0) begin
                    sh = 8 * int'(a[1:0]);
                    m  = 32'hFF << sh;
                end else begin
                    sh = 16 * int'(a[1]);
                    m  = 32'hFFFF << sh;
                end
                ref_mem[e.widx] = (v & ~m) | ((d << sh) & m);
            end
        end
        e.rd    = model_rd;
        e.word  = ref_mem[e.widx];
        e.issue = cyc;
        q.push_back(e);
        req = 1'b1; we = w; size = s; addr = a; wd = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; size = 3'b000; addr = 32'h0; wd = 32'h0;
        n = 0;
        while (!ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, e.lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_rd = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // SH 0x100 with reset during ACCESS: dropped, no write, no done
        req = 1'b1; we = 1'b1; size = 3'b001; addr = 32'h100; wd = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; size = 3'b000; addr = 32'h0; wd = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset_ready", {31'b0, ready}, 32'h1);
        chk("post_reset_done", {31'b0, done}, 32'h0);
        repeat (4) @(negedge clk);
        chk("reset_no_write", mem[64], 32'h8899AABB);
        chk("reset_no_we", we_total, 32'h0);

        // Directed cases around word 0x100 = 0x8899AABB
        issue(1'b0, 3'b000, 32'h101, 32'h0);
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        issue(1'b0, 3'b001, 32'h102, 32'h0);
        issue(1'b1, 3'b000, 32'h103, 32'h00000012);
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        issue(1'b1, 3'b001, 32'h101, 32'h5555AAAA);
        issue(1'b1, 3'b100, 32'h104, 32'h1);
        issue(1'b0, 3'b111, 32'h108, 32'h0);

        // Random traffic over a 64-byte window
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 63)), $urandom);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'h0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("final_memory", bad, 32'h0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
